// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 frame-buffer feeder: FSM state encoding and
// small width helpers.
`ifndef HUB75_PKG_SV
`define HUB75_PKG_SV

`define HUB75_MIN(a, b) (((a) < (b)) ? (a) : (b))
`define HUB75_MAX(a, b) (((a) > (b)) ? (a) : (b))

package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_COMMIT   = 3'd3,
    ST_FLUSH    = 3'd4,
    ST_SWAP     = 3'd5
  } state_t;

endpackage

`endif

// File: rtl/hub75_fb_feeder_if.sv
// Pixel-stream and frame-buffer-write bundles used by hub75_fb_feeder.
// Stream handshake: a pixel transfers on a rising clk edge where in_valid & in_ready.

interface hub75_px_if #(
  parameter int BITDEPTH = 24
);
  logic [BITDEPTH-1:0] in_data;
  logic                in_sof;
  logic                in_valid;
  logic                in_ready;

  modport master (output in_data, in_sof, in_valid, input in_ready);
  modport slave  (input in_data, in_sof, in_valid, output in_ready);
endinterface

interface hub75_fbw_if #(
  parameter int BITDEPTH    = 24,
  parameter int LOG_N_BANKS = 1,
  parameter int LOG_N_ROWS  = 5,
  parameter int LOG_N_COLS  = 6
);
  logic [LOG_N_BANKS-1:0] wr_bank_addr;
  logic [LOG_N_ROWS-1:0]  wr_row_addr;
  logic                   wr_row_store;
  logic                   wr_row_rdy;
  logic                   wr_row_swap;
  logic [BITDEPTH-1:0]    wr_data;
  logic [LOG_N_COLS-1:0]  wr_col_addr;
  logic                   wr_en;
  logic                   frame_swap;

  modport master (
    output wr_bank_addr, wr_row_addr, wr_row_store, wr_row_swap,
           wr_data, wr_col_addr, wr_en, frame_swap,
    input  wr_row_rdy
  );
  modport slave (
    input  wr_bank_addr, wr_row_addr, wr_row_store, wr_row_swap,
           wr_data, wr_col_addr, wr_en, frame_swap,
    output wr_row_rdy
  );
endinterface

// File: rtl/hub75_fb_feeder.sv
// Writes a raster pixel stream row by row into the frame buffer line buffer,
// commits each row to its bank/row and swaps frames once a full frame is stored.

module hub75_fb_feeder
  import hub75_pkg::*;
#(
  parameter int N_BANKS     = 2,
  parameter int N_ROWS      = 32,
  parameter int N_COLS      = 64,
  parameter int BITDEPTH    = 24,
  parameter int LOG_N_BANKS = $clog2(N_BANKS),
  parameter int LOG_N_ROWS  = $clog2(N_ROWS),
  parameter int LOG_N_COLS  = $clog2(N_COLS)
) (
  input  logic        clk,
  input  logic        rst,
  hub75_px_if.slave   px,
  hub75_fbw_if.master fbw,
  output logic        err_resync,
  output logic        busy,
  output state_t      dbg_state
);

  localparam int YW = LOG_N_BANKS + LOG_N_ROWS;
  localparam logic [LOG_N_COLS-1:0] X_LAST = LOG_N_COLS'(N_COLS - 1);
  localparam logic [YW-1:0]         Y_LAST = YW'(N_BANKS * N_ROWS - 1);

  state_t                 state_q, state_d;
  logic [LOG_N_COLS-1:0]  x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic                   flush_wait_q, flush_wait_d;

  logic                   in_ready_q, in_ready_d;
  logic                   wr_en_q, wr_en_d;
  logic [BITDEPTH-1:0]    wr_data_q, wr_data_d;
  logic [LOG_N_COLS-1:0]  wr_col_q, wr_col_d;
  logic                   commit_q, commit_d;
  logic [LOG_N_BANKS-1:0] bank_q, bank_d;
  logic [LOG_N_ROWS-1:0]  row_q, row_d;
  logic                   frame_swap_q, frame_swap_d;
  logic                   resync_q, resync_d;
  logic                   busy_q, busy_d;

  logic                   accept;
  logic                   take;
  logic                   restart;
  logic [LOG_N_COLS-1:0]  x_wr;

  assign accept = px.in_valid & in_ready_q;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    flush_wait_d = 1'b0;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    wr_col_d     = wr_col_q;
    commit_d     = 1'b0;
    bank_d       = bank_q;
    row_d        = row_q;
    frame_swap_d = 1'b0;
    resync_d     = 1'b0;
    take         = 1'b0;
    restart      = 1'b0;
    x_wr         = x_q;

    case (state_q)
      ST_IDLE: begin
        if (accept && px.in_sof) begin
          take    = 1'b1;
          restart = 1'b1;
        end
      end
      ST_FILL: begin
        if (accept) begin
          take = 1'b1;
          // A start-of-frame anywhere but the frame origin abandons the partial row.
          if (px.in_sof && (x_q != '0 || y_q != '0)) begin
            restart  = 1'b1;
            resync_d = 1'b1;
          end
        end
      end
      ST_WAIT_RDY: begin
        if (fbw.wr_row_rdy) begin
          state_d  = ST_COMMIT;
          commit_d = 1'b1;
          bank_d   = y_q[YW-1:LOG_N_ROWS];
          row_d    = y_q[LOG_N_ROWS-1:0];
        end
      end
      ST_COMMIT: begin
        if (y_q == Y_LAST) begin
          y_d          = '0;
          state_d      = ST_FLUSH;
          flush_wait_d = 1'b1;
        end else begin
          y_d     = y_q + 1'b1;
          state_d = ST_FILL;
        end
      end
      ST_FLUSH: begin
        // The frame buffer may still show the pre-store ready for one cycle.
        if (!flush_wait_q && fbw.wr_row_rdy) begin
          state_d      = ST_SWAP;
          frame_swap_d = 1'b1;
        end
      end
      ST_SWAP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (take) begin
      x_wr      = restart ? '0 : x_q;
      wr_en_d   = 1'b1;
      wr_data_d = px.in_data;
      wr_col_d  = x_wr;
      if (restart) y_d = '0;
      if (x_wr == X_LAST) begin
        x_d     = '0;
        state_d = ST_WAIT_RDY;
      end else begin
        x_d     = x_wr + 1'b1;
        state_d = ST_FILL;
      end
    end

    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_FILL);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      flush_wait_q <= 1'b0;
      in_ready_q   <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      wr_col_q     <= '0;
      commit_q     <= 1'b0;
      bank_q       <= '0;
      row_q        <= '0;
      frame_swap_q <= 1'b0;
      resync_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      flush_wait_q <= flush_wait_d;
      in_ready_q   <= in_ready_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      wr_col_q     <= wr_col_d;
      commit_q     <= commit_d;
      bank_q       <= bank_d;
      row_q        <= row_d;
      frame_swap_q <= frame_swap_d;
      resync_q     <= resync_d;
      busy_q       <= busy_d;
    end
  end

  assign px.in_ready      = in_ready_q;
  assign fbw.wr_en        = wr_en_q;
  assign fbw.wr_data      = wr_data_q;
  assign fbw.wr_col_addr  = wr_col_q;
  assign fbw.wr_row_store = commit_q;
  assign fbw.wr_row_swap  = commit_q;
  assign fbw.wr_bank_addr = bank_q;
  assign fbw.wr_row_addr  = row_q;
  assign fbw.frame_swap   = frame_swap_q;
  assign err_resync       = resync_q;
  assign busy             = busy_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_hub75_fb_feeder.sv
// Randomised bench for hub75_fb_feeder on a 2x2x4 panel with a frame-level
// reference model and a scoreboard on the line-buffer and commit traffic.

module tb_hub75_fb_feeder;
  import hub75_pkg::*;

  localparam int NB = 2;
  localparam int NR = 2;
  localparam int NC = 4;
  localparam int BD = 24;
  localparam int LB = 1;
  localparam int LR = 1;
  localparam int LC = 2;
  localparam int W  = BD + LC;
  localparam int FRAME = NB * NR * NC;

  logic   clk;
  logic   rst;
  logic   err_resync;
  logic   busy;
  state_t dbg_state;

  hub75_px_if  #(.BITDEPTH(BD)) px ();
  hub75_fbw_if #(.BITDEPTH(BD), .LOG_N_BANKS(LB), .LOG_N_ROWS(LR), .LOG_N_COLS(LC)) fbw ();

  hub75_fb_feeder #(
    .N_BANKS(NB), .N_ROWS(NR), .N_COLS(NC), .BITDEPTH(BD)
  ) dut (
    .clk(clk), .rst(rst), .px(px), .fbw(fbw),
    .err_resync(err_resync), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0]     exp_q[$];
  logic [LB+LR-1:0] exp_cm_q[$];
  logic             exp_sw_q[$];
  logic [W-1:0]     log_q[$];

  int n_wr = 0, n_commit = 0, n_swap = 0, obs_resync = 0;
  int last_commit_cyc = 0;
  logic prev_store = 1'b0, prev_fswap = 1'b0, prev_rs = 1'b0;

  // reference model (frame-level view of the pixel stream)
  bit m_active = 0;
  int m_x = 0, m_y = 0, m_resync = 0;

  bit stall_req = 0;
  bit stall_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_px(input logic [BD-1:0] d, input logic sof);
    if (!m_active) begin
      if (!sof) return;
      m_active = 1;
      m_x = 0;
      m_y = 0;
    end else if (sof && (m_x != 0 || m_y != 0)) begin
      m_resync++;
      m_x = 0;
      m_y = 0;
    end
    exp_q.push_back({d, LC'(m_x)});
    m_x++;
    if (m_x == NC) begin
      exp_cm_q.push_back({LB'(m_y / NR), LR'(m_y % NR)});
      m_x = 0;
      m_y++;
      if (m_y == NB * NR) begin
        exp_sw_q.push_back(1'b1);
        m_active = 0;
        m_y = 0;
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_store = 1'b0;
      prev_fswap = 1'b0;
      prev_rs    = 1'b0;
    end else begin
      if (fbw.wr_en) begin
        n_wr++;
        log_q.push_back({fbw.wr_data, fbw.wr_col_addr});
        check("store_excl_wr_en", fbw.wr_row_store | fbw.wr_row_swap, 0);
        if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
        else check("wr_data_col", {fbw.wr_data, fbw.wr_col_addr}, exp_q.pop_front());
      end
      if (fbw.wr_row_store || fbw.wr_row_swap) begin
        n_commit++;
        check("row_swap_eq_store", fbw.wr_row_swap, fbw.wr_row_store);
        check("store_width", prev_store, 0);
        if (exp_cm_q.size() == 0) check("commit_unexpected", 1, 0);
        else check("commit_bank_row", {fbw.wr_bank_addr, fbw.wr_row_addr}, exp_cm_q.pop_front());
        last_commit_cyc = cyc;
      end
      if (fbw.frame_swap) begin
        n_swap++;
        check("fswap_width", prev_fswap, 0);
        if (exp_sw_q.size() == 0) check("fswap_unexpected", 1, 0);
        else begin
          void'(exp_sw_q.pop_front());
          check("fswap_delay", cyc - last_commit_cyc, 3);
        end
      end
      if (err_resync) begin
        obs_resync++;
        check("resync_width", prev_rs, 0);
      end
      prev_store = fbw.wr_row_store;
      prev_fswap = fbw.frame_swap;
      prev_rs    = err_resync;
    end
  end

  // ---------------- frame-buffer ready responder ----------------
  initial begin
    fbw.wr_row_rdy = 1'b1;
    stall_done = 0;
    forever begin
      @(negedge clk);
      if (stall_req && !stall_done && fbw.wr_row_store) begin
        stall_done = 1;
        fbw.wr_row_rdy = 1'b0;
        for (int k = 1; k <= 10; k++) begin
          @(negedge clk);
          if (k >= 6) begin
            check("stall_in_ready", px.in_ready, 0);
            check("stall_no_store", fbw.wr_row_store, 0);
          end
        end
        fbw.wr_row_rdy = 1'b1;
        @(negedge clk);
        check("commit_after_rdy", fbw.wr_row_store, 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_bus();
    @(negedge clk);
    px.in_valid = 1'b0;
    px.in_sof   = 1'b0;
  endtask

  task automatic send_px(input logic [BD-1:0] d, input logic sof, input bit gaps);
    int  waitc = 0;
    bit  acc = 0;
    if (gaps) begin
      while ($urandom_range(1, 0) == 1) begin
        @(negedge clk);
        px.in_valid = 1'b0;
        px.in_data  = BD'($urandom);
        px.in_sof   = 1'($urandom);
        @(posedge clk);
      end
    end
    @(negedge clk);
    px.in_valid = 1'b1;
    px.in_data  = d;
    px.in_sof   = sof;
    while (1) begin
      acc = px.in_ready;
      @(posedge clk);
      if (acc) break;
      waitc++;
      if (waitc > 200) begin
        check("accept_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    if (acc) model_px(d, sof);
  endtask

  task automatic send_frame(input logic [BD-1:0] base, input bit gaps, input bit rnd);
    for (int i = 0; i < FRAME; i++)
      send_px(rnd ? BD'($urandom) : base + BD'(i), (i == 0), gaps);
  endtask

  task automatic wait_idle();
    int n = 0;
    idle_bus();
    while (busy || exp_q.size() != 0 || exp_cm_q.size() != 0 || exp_sw_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        check("idle_timeout", 0, 1);
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int s_gapless, s_gapped, w0, c0, sw0, r0, n;

  initial begin
    rst = 1'b1;
    px.in_valid = 1'b0;
    px.in_sof   = 1'b0;
    px.in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", px.in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_wr_en", fbw.wr_en, 0);
    check("rst_store", fbw.wr_row_store, 0);
    check("rst_row_swap", fbw.wr_row_swap, 0);
    check("rst_frame_swap", fbw.frame_swap, 0);
    check("rst_resync", err_resync, 0);
    check("rst_addrs", {fbw.wr_bank_addr, fbw.wr_row_addr, fbw.wr_col_addr, fbw.wr_data}, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;

    // gapless frame, data = pixel index
    s_gapless = log_q.size();
    w0 = n_wr; c0 = n_commit; sw0 = n_swap;
    send_frame('0, 0, 0);
    wait_idle();
    check("frame1_writes", n_wr - w0, FRAME);
    check("frame1_commits", n_commit - c0, NB * NR);
    check("frame1_swaps", n_swap - sw0, 1);

    // stray pixels before sof are dropped
    w0 = n_wr;
    for (int i = 0; i < 3; i++) send_px(BD'($urandom), 1'b0, 0);
    send_frame('0, 0, 1);
    wait_idle();
    check("discard_writes", n_wr - w0, FRAME);

    // frame-buffer back-pressure after row 0
    stall_req = 1;
    c0 = n_commit;
    send_frame(24'h100, 0, 0);
    wait_idle();
    stall_req = 0;
    check("stall_commits", n_commit - c0, NB * NR);

    // resync: sof on pixel 6 (row 1, x=2) restarts the frame
    r0 = obs_resync; c0 = n_commit; sw0 = n_swap;
    for (int i = 0; i < 6 + FRAME; i++)
      send_px(24'h200 + BD'(i), (i == 0) || (i == 6), 0);
    wait_idle();
    check("resync_count", obs_resync - r0, 1);
    check("resync_commits", n_commit - c0, 1 + NB * NR);
    check("resync_swaps", n_swap - sw0, 1);

    // reset during FLUSH drops the pending frame swap
    c0 = n_commit; sw0 = n_swap;
    send_frame('0, 0, 1);
    n = 0;
    while (n_commit < c0 + NB * NR && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("flush_reached", n_commit - c0, NB * NR);
    @(negedge clk);
    check("flush_state", dbg_state, ST_FLUSH);
    exp_sw_q.delete();
    exp_q.delete();
    exp_cm_q.delete();
    m_active = 0; m_x = 0; m_y = 0;
    px.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_flush_in_ready", px.in_ready, 1);
    check("rst_flush_busy", busy, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_flush_no_swap", n_swap - sw0, 0);
    send_frame('0, 0, 1);
    wait_idle();
    check("post_rst_swaps", n_swap - sw0, 1);

    // same data as the first frame with random valid gaps
    s_gapped = log_q.size();
    send_frame('0, 1, 0);
    wait_idle();
    check("gapped_len", log_q.size() - s_gapped, FRAME);
    if (log_q.size() - s_gapped == FRAME && s_gapped - s_gapless >= FRAME)
      for (int i = 0; i < FRAME; i++)
        check("gapped_vs_gapless", log_q[s_gapped + i], log_q[s_gapless + i]);

    check("final_wr_q_empty", exp_q.size(), 0);
    check("final_cm_q_empty", exp_cm_q.size(), 0);
    check("final_sw_q_empty", exp_sw_q.size(), 0);
    check("final_resync_total", obs_resync, m_resync);
    check("final_swap_total", n_swap, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
